// File: rtl/tpc_program_loader.sv
// Job-level front end for one TPC: buffers an instruction stream, writes it into TPC instruction
// memory over noc_rx, optionally starts the TPC and reports completion, error or timeout.
module tpc_program_loader #(
  parameter int unsigned SRAM_WIDTH  = 256,
  parameter int unsigned SRAM_ADDR_W = 20,
  parameter int unsigned INSTR_W     = 128,
  parameter int unsigned LEN_W       = 12,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [SRAM_ADDR_W-1:0] job_base_pc,
  input  logic [LEN_W-1:0]       job_len,
  input  logic                   job_run,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  input  logic [INSTR_W-1:0]     instr_data,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  output logic [SRAM_WIDTH-1:0]  noc_rx_data,
  output logic [SRAM_ADDR_W-1:0] noc_rx_addr,
  output logic                   noc_rx_valid,
  input  logic                   noc_rx_ready,
  output logic                   noc_rx_is_instr,
  output logic                   tpc_start,
  output logic [SRAM_ADDR_W-1:0] tpc_start_pc,
  input  logic                   tpc_busy,
  input  logic                   tpc_done,
  input  logic                   tpc_error,
  output logic                   busy,
  output logic                   job_done,
  output logic [1:0]             job_status
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StReport} state_e;

  state_e                 state_q;
  logic [SRAM_ADDR_W-1:0] base_pc_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       acc_cnt_q;
  logic [LEN_W-1:0]       wr_cnt_q;
  logic                   run_q;
  logic [TIMEOUT_W-1:0]   limit_q;
  logic [TIMEOUT_W-1:0]   tmo_cnt_q;
  logic                   seen_busy_q;

  logic [INSTR_W-1:0]     fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W:0]         count_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic qual;
  logic last_write;
  logic tmo_hit;

  always_comb begin
    fifo_full       = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    fifo_empty      = (count_q == '0);
    instr_ready     = (state_q == StLoad) && !fifo_full && (acc_cnt_q < len_q);
    push            = instr_valid && instr_ready;
    noc_rx_valid    = (state_q == StLoad) && !fifo_empty;
    noc_rx_is_instr = noc_rx_valid;
    pop             = noc_rx_valid && noc_rx_ready;
    noc_rx_data     = {{(SRAM_WIDTH - INSTR_W){1'b0}}, fifo_mem[rd_ptr_q]};
    noc_rx_addr     = base_pc_q + SRAM_ADDR_W'(wr_cnt_q);
    busy            = (state_q != StIdle);
    tpc_start_pc    = base_pc_q;
    // Done/error only count once busy has been seen, so a stale done from the last job is ignored.
    qual            = seen_busy_q || tpc_busy;
    last_write      = pop && (wr_cnt_q == len_q - LEN_W'(1));
    tmo_hit         = (limit_q != '0) && (tmo_cnt_q == limit_q - TIMEOUT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= instr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_pc_q   <= '0;
      len_q       <= '0;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      run_q       <= 1'b0;
      limit_q     <= '0;
      tmo_cnt_q   <= '0;
      seen_busy_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      job_ready   <= 1'b1;
      tpc_start   <= 1'b0;
      job_done    <= 1'b0;
      job_status  <= 2'b00;
    end else begin
      tpc_start <= 1'b0;
      job_done  <= 1'b0;

      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
        acc_cnt_q <= acc_cnt_q + LEN_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        wr_cnt_q <= wr_cnt_q + LEN_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase

      unique case (state_q)
        StIdle: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready  <= 1'b0;
            base_pc_q  <= job_base_pc;
            len_q      <= job_len;
            run_q      <= job_run;
            limit_q    <= timeout_limit;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            job_status <= 2'b00;
            if (job_len != '0) begin
              state_q <= StLoad;
            end else if (job_run) begin
              state_q   <= StStart;
              tpc_start <= 1'b1;
            end else begin
              state_q <= StReport;
            end
          end
        end
        StLoad: begin
          if (last_write) begin
            if (run_q) begin
              state_q   <= StStart;
              tpc_start <= 1'b1;
            end else begin
              state_q <= StReport;
            end
          end
        end
        StStart: begin
          seen_busy_q <= 1'b0;
          tmo_cnt_q   <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          seen_busy_q <= seen_busy_q || tpc_busy;
          tmo_cnt_q   <= tmo_cnt_q + TIMEOUT_W'(1);
          if (tpc_error && qual) begin
            job_status <= 2'b01;
            state_q    <= StReport;
          end else if (tpc_done && qual) begin
            job_status <= 2'b00;
            state_q    <= StReport;
          end else if (tmo_hit) begin
            job_status <= 2'b10;
            state_q    <= StReport;
          end
        end
        StReport: begin
          job_done <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/tpc_program_loader.md
Name: tpc_program_loader

Overview:
Upstream feeder for tensor_processing_cluster. It accepts a job descriptor (base PC, instruction count, run flag) and a stream of 128-bit instructions. It writes the instructions into TPC instruction memory through the TPC's noc_rx port, then pulses tpc_start and waits for completion. Completion is reported as a one-cycle job_done with a status code. It replaces the manual load/start sequencing the bench does today and is the unit the global command processor will instantiate per TPC.

Parameters:
SRAM_WIDTH, 256, width of noc_rx_data
SRAM_ADDR_W, 20, width of instruction addresses / PC
INSTR_W, 128, instruction width; zero-extended into SRAM_WIDTH
LEN_W, 12, width of job_len
FIFO_DEPTH, 4, instruction buffer entries (power of two, >=2)
TIMEOUT_W, 16, width of timeout counter/limit

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
job_valid  in  1  job descriptor valid
job_ready  out  1  loader can accept a job (high only in IDLE)
job_base_pc  in  SRAM_ADDR_W  first instruction address, also start PC
job_len  in  LEN_W  number of instructions to load (0 = none)
job_run  in  1  start TPC after load
timeout_limit  in  TIMEOUT_W  max WAIT cycles; 0 disables timeout
instr_data  in  INSTR_W  instruction word
instr_valid  in  1  instruction valid
instr_ready  out  1  instruction accepted when valid&ready
noc_rx_data  out  SRAM_WIDTH  {zeros, instr}
noc_rx_addr  out  SRAM_ADDR_W  write address
noc_rx_valid  out  1  write request
noc_rx_ready  in  1  TPC accepts write
noc_rx_is_instr  out  1  equals noc_rx_valid
tpc_start  out  1  one-cycle start pulse
tpc_start_pc  out  SRAM_ADDR_W  start PC, held from job accept
tpc_busy  in  1  TPC executing
tpc_done  in  1  TPC finished (level; may be stale-high)
tpc_error  in  1  TPC error flag
busy  out  1  state != IDLE
job_done  out  1  one-cycle completion pulse
job_status  out  2  00 ok, 01 tpc_error, 10 timeout; held until next job accept

Behaviour:
- Reset: FSM=IDLE, FIFO empty, counters 0. All outputs 0 except job_ready=1. Asserting rst_n low mid-job aborts immediately; no further noc or tpc traffic.
- States: IDLE, LOAD, START, WAIT, REPORT.
- IDLE: on job_valid&job_ready, latch base_pc, len, run, timeout_limit. Clear accept/write counters and job_status. Next state:
  - LOAD if len!=0;
  - else START if run;
  - else REPORT.
- LOAD, ingress: instr_ready = (state==LOAD) & FIFO not full & accepted_cnt<len. Instructions are never accepted outside LOAD.
- LOAD, egress: noc_rx_valid = FIFO non-empty (registered FIFO). First write is visible the cycle after the first instr handshake.
  - noc_rx_addr = base_pc + write_cnt, modulo 2^SRAM_ADDR_W (wraps).
  - data/addr/valid held stable while valid&!ready.
  - write_cnt increments on noc_rx_valid&noc_rx_ready.
- When write_cnt reaches len: go to START if run, else REPORT. A full FIFO stalls ingress only; no data loss.
- START: tpc_start=1 for exactly one cycle, tpc_start_pc=base_pc. Clear seen_busy and the timeout counter. Go to WAIT.
- WAIT: seen_busy is set on any cycle with tpc_busy=1. tpc_done/tpc_error are qualified only when seen_busy, or in the same cycle busy is first seen, which rejects stale done. The timeout counter increments every WAIT cycle. Exit conditions, in priority order:
  - tpc_error qualified → status 01;
  - tpc_done qualified → 00;
  - limit!=0 & counter==limit-1 → 10.
  - Done and error in the same cycle → 01.
- REPORT: job_done=1 for one cycle, then IDLE. job_ready rises the cycle after job_done. A non-run job reports 00.
- job_len=0 with job_run=0: job_done two cycles after accept.

Test Plan:
- Reset: after rst_n rise → job_ready=1; busy, noc_rx_valid, tpc_start, job_done all 0.
- Load 3 words (NOP, NOP, HALT 0xFF<<120) at base 0x010, run=1, noc_rx_ready=1:
  - writes to 0x010/0x011/0x012 with noc_rx_is_instr=1 and upper 128 bits zero;
  - one tpc_start pulse, tpc_start_pc=0x010;
  - model busy 5 cycles then done → job_done, status 00.
- Backpressure: noc_rx_ready toggled 1-of-3 cycles, 8 words with FIFO_DEPTH=4:
  - instr_ready drops when the FIFO is full;
  - all 8 writes arrive in order at consecutive addresses, each held stable while stalled.
- Stale done: tpc_done held high from the previous job at START → no early completion; completes only after busy rises then done.
- Error/timeout:
  - tpc_error after busy → status 01;
  - timeout_limit=10 with TPC never done → job_done exactly 10 WAIT cycles after START, status 10.
- Edge cases:
  - base_pc=0xFFFFF, len=2 → addresses 0xFFFFF then 0x00000;
  - len=0, run=0 → job_done 2 cycles after accept, no noc/tpc activity;
  - rst_n pulsed low mid-LOAD → all outputs 0 and job_ready=1 after release.
